// File: rtl/serv_bus_pkg.sv
// Shared types and limits for the SERV bus responder.
// One channel state machine per bus; requests are latched in IDLE.
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } chan_state_e;

  localparam int WAIT_W       = 2;
  localparam int MAX_WAIT_LIM = 2;

  typedef struct packed {
    logic        fire;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } req_t;

  function automatic logic [WAIT_W-1:0] clamp_wait(
    input logic [WAIT_W-1:0] req,
    input logic [WAIT_W-1:0] lim
  );
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/serv_bus_chan.sv
// One Wishbone responder channel: wait-state FSM, read data,
// saturating completion counter and protocol-error detect.
module serv_bus_chan
  import serv_bus_pkg::*;
#(
  parameter int MAX_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              cyc,
  input  logic [31:0]       adr,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [31:0]       dat,
  input  logic [31:0]       word,
  input  logic [WAIT_W-1:0] wt,
  output logic [31:0]       rdt,
  output logic              ack,
  output logic [CNT_W-1:0]  cnt,
  output logic              err,
  output req_t              req
);

  localparam logic [WAIT_W-1:0] MW = WAIT_W'(MAX_WAIT);

  chan_state_e       state;
  logic [WAIT_W-1:0] wcnt;
  logic [WAIT_W-1:0] w;
  logic [31:0]       adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic              go_ack;
  logic              bad;

  always_comb begin
    w      = clamp_wait(wt, MW);
    go_ack = 1'b0;
    unique case (state)
      IDLE:    go_ack = cyc && (w == '0);
      WAIT:    go_ack = (wcnt == '0);
      default: go_ack = 1'b0;
    endcase
    bad = ((state != IDLE) && !cyc)
       || ((state == WAIT)
           && ((adr != adr_q) || (we != we_q)));
    // In IDLE the request is being latched this edge,
    // so expose the live inputs instead of stale latches.
    req.fire = go_ack && cyc;
    req.we   = (state == IDLE) ? we  : we_q;
    req.adr  = (state == IDLE) ? adr : adr_q;
    req.dat  = (state == IDLE) ? dat : dat_q;
    req.sel  = (state == IDLE) ? sel : sel_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      rdt   <= '0;
      ack   <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      ack <= req.fire;
      rdt <= (req.fire && !req.we) ? word : '0;
      if (bad)
        err <= 1'b1;
      if (ack && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (cyc) begin
            adr_q <= adr;
            dat_q <= dat;
            sel_q <= sel;
            we_q  <= we;
            if (w == '0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              wcnt  <= w - WAIT_W'(1);
            end
          end
        end
        WAIT: begin
          if (wcnt == '0)
            state <= ACK;
          else
            wcnt <= wcnt - WAIT_W'(1);
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serv_bus_responder.sv
// Bounded-latency ibus/dbus responder for the SERV core.
// Two independent channels plus dbus write capture.
module serv_bus_responder
  import serv_bus_pkg::*;
#(
  parameter int MAX_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_ibus_adr,
  input  logic             i_ibus_cyc,
  input  logic [31:0]      i_ibus_word,
  input  logic [1:0]       i_ibus_wait,
  output logic [31:0]      o_ibus_rdt,
  output logic             o_ibus_ack,
  input  logic [31:0]      i_dbus_adr,
  input  logic [31:0]      i_dbus_dat,
  input  logic [3:0]       i_dbus_sel,
  input  logic             i_dbus_we,
  input  logic             i_dbus_cyc,
  input  logic [31:0]      i_dbus_word,
  input  logic [1:0]       i_dbus_wait,
  output logic [31:0]      o_dbus_rdt,
  output logic             o_dbus_ack,
  output logic             o_wr_valid,
  output logic [31:0]      o_wr_adr,
  output logic [31:0]      o_wr_dat,
  output logic [3:0]       o_wr_sel,
  output logic [CNT_W-1:0] o_ibus_cnt,
  output logic [CNT_W-1:0] o_dbus_cnt,
  output logic             o_proto_err
);

  if (MAX_WAIT < 0 || MAX_WAIT > MAX_WAIT_LIM) begin : g_bad_wait
    $error("serv_bus_responder: MAX_WAIT out of range");
  end

  req_t ibus_unused;
  req_t dbus_req;
  logic ibus_err;
  logic dbus_err;

  serv_bus_chan #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_ibus (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .cyc     (i_ibus_cyc),
    .adr     (i_ibus_adr),
    .we      (1'b0),
    .sel     (4'h0),
    .dat     (32'h0),
    .word    (i_ibus_word),
    .wt      (i_ibus_wait),
    .rdt     (o_ibus_rdt),
    .ack     (o_ibus_ack),
    .cnt     (o_ibus_cnt),
    .err     (ibus_err),
    .req     (ibus_unused)
  );

  serv_bus_chan #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_dbus (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .cyc     (i_dbus_cyc),
    .adr     (i_dbus_adr),
    .we      (i_dbus_we),
    .sel     (i_dbus_sel),
    .dat     (i_dbus_dat),
    .word    (i_dbus_word),
    .wt      (i_dbus_wait),
    .rdt     (o_dbus_rdt),
    .ack     (o_dbus_ack),
    .cnt     (o_dbus_cnt),
    .err     (dbus_err),
    .req     (dbus_req)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_valid <= 1'b0;
      o_wr_adr   <= '0;
      o_wr_dat   <= '0;
      o_wr_sel   <= '0;
    end else begin
      o_wr_valid <= dbus_req.fire && dbus_req.we;
      if (dbus_req.fire && dbus_req.we) begin
        o_wr_adr <= dbus_req.adr;
        o_wr_dat <= dbus_req.dat;
        o_wr_sel <= dbus_req.sel;
      end
    end
  end

  assign o_proto_err = ibus_err | dbus_err;

endmodule

// File: tb/tb_serv_bus_responder.sv
// Scoreboard bench for serv_bus_responder: drivers push expected
// acks, a negedge monitor pops and compares them.
module tb_serv_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus_adr = '0;
  logic        ibus_cyc = 1'b0;
  logic [31:0] ibus_word = '0;
  logic [1:0]  ibus_wait = '0;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr = '0;
  logic [31:0] dbus_dat = '0;
  logic [3:0]  dbus_sel = '0;
  logic        dbus_we = 1'b0;
  logic        dbus_cyc = 1'b0;
  logic [31:0] dbus_word = '0;
  logic [1:0]  dbus_wait = '0;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic        wr_valid;
  logic [31:0] wr_adr;
  logic [31:0] wr_dat;
  logic [3:0]  wr_sel;
  logic [15:0] ibus_cnt;
  logic [15:0] dbus_cnt;
  logic        proto_err;
  logic [1:0]  sat_ibus_cnt;
  logic [1:0]  sat_dbus_cnt;
  logic [31:0] unused_sat_irdt;
  logic [31:0] unused_sat_drdt;
  logic        unused_sat_iack;
  logic        unused_sat_dack;
  logic        unused_sat_wv;
  logic [31:0] unused_sat_wadr;
  logic [31:0] unused_sat_wdat;
  logic [3:0]  unused_sat_wsel;
  logic        unused_sat_err;

  always #5 clk = ~clk;

  serv_bus_responder u_dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
    .i_ibus_word(ibus_word), .i_ibus_wait(ibus_wait),
    .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat),
    .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .i_dbus_word(dbus_word),
    .i_dbus_wait(dbus_wait),
    .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .o_wr_valid(wr_valid), .o_wr_adr(wr_adr),
    .o_wr_dat(wr_dat), .o_wr_sel(wr_sel),
    .o_ibus_cnt(ibus_cnt), .o_dbus_cnt(dbus_cnt),
    .o_proto_err(proto_err)
  );

  serv_bus_responder #(.CNT_W(2)) u_sat (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
    .i_ibus_word(ibus_word), .i_ibus_wait(ibus_wait),
    .o_ibus_rdt(unused_sat_irdt), .o_ibus_ack(unused_sat_iack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat),
    .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .i_dbus_word(dbus_word),
    .i_dbus_wait(dbus_wait),
    .o_dbus_rdt(unused_sat_drdt), .o_dbus_ack(unused_sat_dack),
    .o_wr_valid(unused_sat_wv), .o_wr_adr(unused_sat_wadr),
    .o_wr_dat(unused_sat_wdat), .o_wr_sel(unused_sat_wsel),
    .o_ibus_cnt(sat_ibus_cnt), .o_dbus_cnt(sat_dbus_cnt),
    .o_proto_err(unused_sat_err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdt;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  int          last_ack[2];
  int          acks[2];
  int          err_at;
  bit          mon_en = 1'b0;
  logic [31:0] m_wadr;
  logic [31:0] m_wdat;
  logic [3:0]  m_wsel;
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    acks     = '{0, 0};
    last_ack = '{-100, -100};
    err_at   = 0;
    m_wadr   = '0;
    m_wdat   = '0;
    m_wsel   = '0;
    iq.delete();
    dq.delete();
  endtask

  task automatic set_cyc(input bit d, input logic v);
    if (d) dbus_cyc = v;
    else   ibus_cyc = v;
  endtask

  // Call at a negedge. Ack is due w edges after the first edge
  // that finds the channel idle (two edges after the prior ack).
  task automatic do_req(input bit d, input logic [1:0] wt,
                        input logic [31:0] adr,
                        input logic [31:0] dat,
                        input logic [31:0] word,
                        input logic [3:0] sel, input logic we,
                        input bit abandon, input bit keep);
    int   smp;
    int   w;
    int   exp_c;
    exp_t e;
    bit   seen;
    smp   = (cyc_n + 1 > last_ack[d] + 2) ? cyc_n + 1
                                          : last_ack[d] + 2;
    w     = (wt > 2'd2) ? 2 : int'(wt);
    exp_c = smp + w;
    if (d) begin
      dbus_adr = adr; dbus_dat = dat; dbus_sel = sel;
      dbus_we = we; dbus_word = word; dbus_wait = wt;
    end else begin
      ibus_adr = adr; ibus_word = word; ibus_wait = wt;
    end
    set_cyc(d, 1'b1);
    if (abandon) begin
      while (cyc_n < smp) @(negedge clk);
      set_cyc(d, 1'b0);
      if (err_at == 0) err_at = smp + 1;
      while (cyc_n < exp_c) @(negedge clk);
      last_ack[d] = exp_c;
    end else begin
      e = '{exp_c, we ? 32'h0 : word, we, adr, dat, sel};
      if (d) dq.push_back(e);
      else   iq.push_back(e);
      seen = 1'b0;
      do begin
        @(negedge clk);
        seen = d ? dbus_ack : ibus_ack;
      end while (!seen && cyc_n <= exp_c + 2);
      if (!seen) chk(d ? "dbus hang" : "ibus hang", seen, 1);
      last_ack[d] = exp_c;
      if (!keep) begin
        @(negedge clk);
        set_cyc(d, 1'b0);
      end
    end
  endtask

  task automatic mon_bus(input bit d);
    logic        a;
    logic [31:0] r;
    bit          have;
    exp_t        e;
    a    = d ? dbus_ack : ibus_ack;
    r    = d ? dbus_rdt : ibus_rdt;
    have = d ? (dq.size() > 0) : (iq.size() > 0);
    if (have) e = d ? dq[0] : iq[0];
    if (a) begin
      if (!have) begin
        chk(d ? "dbus spurious ack" : "ibus spurious ack", a, 0);
      end else begin
        if (d) void'(dq.pop_front());
        else   void'(iq.pop_front());
        chk(d ? "dbus ack cycle" : "ibus ack cycle", cyc_n, e.cyc);
        chk(d ? "dbus rdt" : "ibus rdt", r, e.rdt);
        if (d) begin
          chk("wr_valid on ack", wr_valid, e.we);
          if (e.we) begin
            m_wadr = e.adr; m_wdat = e.dat; m_wsel = e.sel;
          end
        end
        acks[d]++;
      end
    end else begin
      chk(d ? "dbus rdt idle" : "ibus rdt idle", r, 0);
      if (d) chk("wr_valid idle", wr_valid, 0);
      if (have && cyc_n > e.cyc) begin
        chk(d ? "dbus ack missing" : "ibus ack missing", a, 1);
        if (d) void'(dq.pop_front());
        else   void'(iq.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ibus_cnt", ibus_cnt, sat(acks[0], 65535));
      chk("dbus_cnt", dbus_cnt, sat(acks[1], 65535));
      chk("sat ibus_cnt", sat_ibus_cnt, sat(acks[0], 3));
      chk("sat dbus_cnt", sat_dbus_cnt, sat(acks[1], 3));
      mon_bus(1'b0);
      mon_bus(1'b1);
      chk("wr_adr", wr_adr, m_wadr);
      chk("wr_dat", wr_dat, m_wdat);
      chk("wr_sel", wr_sel, m_wsel);
      chk("proto_err", proto_err, (err_at != 0 && cyc_n >= err_at));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " ibus"}, {ibus_ack, ibus_rdt, ibus_cnt}, 0);
    chk({tag, " dbus"}, {dbus_ack, dbus_rdt, dbus_cnt}, 0);
    chk({tag, " wr"}, {wr_valid, wr_sel, wr_adr}, 0);
    chk({tag, " wr_dat"}, wr_dat, 0);
    chk({tag, " err"}, {proto_err, sat_ibus_cnt, sat_dbus_cnt}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // directed: fetch w=0, clamped store, concurrent fetch/load
    do_req(0, 2'd0, 32'h0, 32'h0, 32'h00B50533, 4'h0, 0, 0, 0);
    do_req(1, 2'd3, 32'h100, 32'hDEADBEEF, 32'h5A5A5A5A, 4'hF,
           1, 0, 0);
    repeat (2) @(negedge clk);
    fork
      do_req(0, 2'd1, 32'h4, 32'h0, 32'h00000013, 4'h0, 0, 0, 0);
      do_req(1, 2'd2, 32'h200, 32'h0, 32'h12345678, 4'hF,
             0, 0, 0);
    join

    // random concurrent traffic with back-to-back requests
    fork
      begin
        int g;
        bit k;
        for (int i = 0; i < 40; i++) begin
          k = (i < 39) && ($urandom_range(0, 2) == 0);
          do_req(0, 2'($urandom_range(0, 3)),
                 $urandom & 32'hFFFF_FFFC, 32'h0, $urandom,
                 4'h0, 0, 0, k);
          g = $urandom_range(0, 2);
          if (!k) repeat (g) @(negedge clk);
        end
      end
      begin
        int g;
        bit k;
        for (int i = 0; i < 40; i++) begin
          k = (i < 39) && ($urandom_range(0, 2) == 0);
          do_req(1, 2'($urandom_range(0, 3)),
                 $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                 4'($urandom_range(0, 15)), 1'($urandom), 0, k);
          g = $urandom_range(0, 2);
          if (!k) repeat (g) @(negedge clk);
        end
      end
    join

    // abandoned store, then clean traffic with the error sticky
    repeat (2) @(negedge clk);
    do_req(1, 2'd2, 32'h400, 32'h55, 32'h0, 4'hF, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      fork
        do_req(0, 2'($urandom_range(0, 3)), 32'h40 + i * 4, 0,
               $urandom, 4'h0, 0, 0, 0);
        do_req(1, 2'($urandom_range(0, 3)), 32'h800 + i * 4,
               $urandom, $urandom, 4'hF, 1'(i), 0, 0);
      join
    end

    // reset while the dbus channel sits in WAIT
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    dbus_adr = 32'h200; dbus_dat = 32'h11; dbus_sel = 4'hF;
    dbus_we = 1'b1; dbus_wait = 2'd2; dbus_cyc = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst mid-wait");
    @(negedge clk);
    chk("wr_valid in reset", wr_valid, 0);
    dbus_cyc = 1'b0;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    do_req(1, 2'd1, 32'h300, 32'h0, 32'hA5A5_0001, 4'hF, 0, 0, 0);
    do_req(0, 2'd2, 32'h8, 32'h0, 32'h0000_0093, 4'h0, 0, 0, 0);

    // reset during the ACK cycle of a store
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    dbus_adr = 32'h310; dbus_dat = 32'hCAFEF00D; dbus_sel = 4'h3;
    dbus_we = 1'b1; dbus_wait = 2'd0; dbus_cyc = 1'b1;
    @(negedge clk);
    chk("ack before reset", dbus_ack, 1);
    chk("wr_valid before reset", wr_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst in ack");
    @(negedge clk);
    chk("wr_valid after ack reset", wr_valid, 0);
    dbus_cyc = 1'b0;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    fork
      do_req(0, 2'd0, 32'hC, 32'h0, 32'h0010_0073, 4'h0, 0, 0, 0);
      do_req(1, 2'd1, 32'h320, 32'hBEEF_0000, 32'h0, 4'hC,
             1, 0, 0);
    join
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
